// File: rtl/pcs_pkg.sv
// Shared 64b/66b PCS definitions: sync headers, block types, CGMII
// characters, 7-bit control codes, TX state encodings and the error block.
package pcs_pkg;

    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTRL = 2'b10;

    localparam logic [7:0] BT_CTRL  = 8'h1E;
    localparam logic [7:0] BT_START = 8'h78;
    localparam logic [7:0] BT_OSET  = 8'h4B;
    localparam logic [7:0] BT_TERM0 = 8'h87;
    localparam logic [7:0] BT_TERM1 = 8'h99;
    localparam logic [7:0] BT_TERM2 = 8'hAA;
    localparam logic [7:0] BT_TERM3 = 8'hB4;
    localparam logic [7:0] BT_TERM4 = 8'hCC;
    localparam logic [7:0] BT_TERM5 = 8'hD2;
    localparam logic [7:0] BT_TERM6 = 8'hE1;
    localparam logic [7:0] BT_TERM7 = 8'hFF;

    localparam logic [7:0] CH_IDLE  = 8'h07;
    localparam logic [7:0] CH_ERROR = 8'hFE;
    localparam logic [7:0] CH_START = 8'hFB;
    localparam logic [7:0] CH_TERM  = 8'hFD;
    localparam logic [7:0] CH_SEQ   = 8'h9C;
    localparam logic [7:0] CH_SIG   = 8'h5C;

    localparam logic [6:0] CC_IDLE  = 7'h00;
    localparam logic [6:0] CC_ERROR = 7'h1E;

    // O-code nibble carried in an ordered-set block
    localparam logic [3:0] OC_SEQ = 4'h0;
    localparam logic [3:0] OC_SIG = 4'hF;

    typedef enum logic [4:0] {
        TX_INIT = 5'b00001,
        TX_C    = 5'b00010,
        TX_D    = 5'b00100,
        TX_T    = 5'b01000,
        TX_E    = 5'b10000
    } tx_state_e;

    typedef enum logic [2:0] {
        CLS_D,
        CLS_C,
        CLS_S,
        CLS_O,
        CLS_T,
        CLS_E
    } blk_class_e;

    localparam logic [65:0] EBLOCK = {SYNC_CTRL, BT_CTRL, {8{CC_ERROR}}};

    // Block type of a terminate block whose FD sits in lane k
    function automatic logic [7:0] term_type(input logic [2:0] k);
        case (k)
            3'd0:    term_type = BT_TERM0;
            3'd1:    term_type = BT_TERM1;
            3'd2:    term_type = BT_TERM2;
            3'd3:    term_type = BT_TERM3;
            3'd4:    term_type = BT_TERM4;
            3'd5:    term_type = BT_TERM5;
            3'd6:    term_type = BT_TERM6;
            default: term_type = BT_TERM7;
        endcase
    endfunction

endpackage

// File: rtl/encoder_64b66b_if.sv
// CGMII-in / coded-block-out bus of the 64b/66b encoder.
// Optional feature macro: ENCODER_ERROR_COUNT_EN adds o_err_count.
interface encoder_64b66b_if #(
    parameter int NB_DATA_RAW = 64,
    parameter int NB_CTRL_RAW = 8,
    parameter int NB_CODED    = 66
) ();
    logic                   i_enable;
    logic [NB_DATA_RAW-1:0] i_tx_data;
    logic [NB_CTRL_RAW-1:0] i_tx_ctrl;
    logic [NB_CODED-1:0]    o_tx_coded;
    logic                   o_valid;
    logic [4:0]             o_state;
`ifdef ENCODER_ERROR_COUNT_EN
    logic [15:0]            o_err_count;

    modport master (output i_enable, i_tx_data, i_tx_ctrl,
                    input  o_tx_coded, o_valid, o_state, o_err_count);
    modport slave  (input  i_enable, i_tx_data, i_tx_ctrl,
                    output o_tx_coded, o_valid, o_state, o_err_count);
`else
    modport master (output i_enable, i_tx_data, i_tx_ctrl,
                    input  o_tx_coded, o_valid, o_state);
    modport slave  (input  i_enable, i_tx_data, i_tx_ctrl,
                    output o_tx_coded, o_valid, o_state);
`endif
endinterface

// File: rtl/encoder_block_classifier.sv
// Combinational classification of one CGMII word into D/C/S/O/Tk/E,
// with the lane index of FD for terminate words.
module encoder_block_classifier
    import pcs_pkg::*;
#(
    parameter int NB_DATA_RAW = 64,
    parameter int NB_CTRL_RAW = 8
) (
    input  logic [NB_DATA_RAW-1:0] i_tx_data,
    input  logic [NB_CTRL_RAW-1:0] i_tx_ctrl,
    output blk_class_e             o_class,
    output logic [2:0]             o_term_k
);

    function automatic logic all_idle_or_error(input logic [63:0] d);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (d[63-8*i -: 8] != CH_IDLE && d[63-8*i -: 8] != CH_ERROR) ok = 1'b0;
        end
        return ok;
    endfunction

    // Lanes before k are data (ctrl bits clear), lane k is FD, the rest idle
    function automatic logic is_term(input logic [63:0] d, input logic [7:0] c, input int k);
        logic ok;
        ok = (c == (8'hFF >> k)) && (d[63-8*k -: 8] == CH_TERM);
        for (int j = k + 1; j < 8; j++) begin
            if (d[63-8*j -: 8] != CH_IDLE) ok = 1'b0;
        end
        return ok;
    endfunction

    logic [7:0] lane0;
    assign lane0 = i_tx_data[NB_DATA_RAW-1 -: 8];

    // Priority chain; the ctrl patterns keep the classes mutually exclusive
    always_comb begin
        o_class  = CLS_E;
        o_term_k = 3'd0;
        if (i_tx_ctrl == 8'h00) begin
            o_class = CLS_D;
        end else if (i_tx_ctrl == 8'hFF && all_idle_or_error(i_tx_data)) begin
            o_class = CLS_C;
        end else if (i_tx_ctrl == 8'h80 && lane0 == CH_START) begin
            o_class = CLS_S;
        end else if (i_tx_ctrl == 8'h80 && (lane0 == CH_SEQ || lane0 == CH_SIG)) begin
            o_class = CLS_O;
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (is_term(i_tx_data, i_tx_ctrl, k)) begin
                    o_class  = CLS_T;
                    o_term_k = k[2:0];
                end
            end
        end
    end

endmodule

// File: rtl/encoder_64b66b.sv
// 64b/66b transmit encoder: classifies each CGMII word, tracks the TX
// state machine and registers one coded block per enabled clock.
// Optional feature macro: ENCODER_ERROR_COUNT_EN adds a saturating
// 16-bit count of emitted error blocks on o_err_count.
module encoder_64b66b
    import pcs_pkg::*;
#(
    parameter int NB_DATA_RAW = 64,
    parameter int NB_CTRL_RAW = 8,
    parameter int NB_CODED    = 66
) (
    input  logic              i_clock,
    input  logic              i_reset,
    encoder_64b66b_if.slave   bus
);

    blk_class_e          blk_class;
    logic [2:0]          term_k;
    tx_state_e           state_p1;
    tx_state_e           state_next;
    logic [NB_CODED-1:0] coded_next;
    logic [NB_CODED-1:0] coded_p1;
    logic                vld_p1;

    encoder_block_classifier #(
        .NB_DATA_RAW (NB_DATA_RAW),
        .NB_CTRL_RAW (NB_CTRL_RAW)
    ) u_classifier (
        .i_tx_data (bus.i_tx_data),
        .i_tx_ctrl (bus.i_tx_ctrl),
        .o_class   (blk_class),
        .o_term_k  (term_k)
    );

    function automatic logic [65:0] encode_block(input blk_class_e cls,
                                                 input logic [2:0] k,
                                                 input logic [63:0] d);
        logic [55:0] codes;
        logic [55:0] keep;
        logic [3:0]  ocode;
        for (int i = 0; i < 8; i++) begin
            codes[55-7*i -: 7] = (d[63-8*i -: 8] == CH_ERROR) ? CC_ERROR : CC_IDLE;
        end
        // Keep the k leading data bytes of a terminate block, zero the rest
        keep  = ~({56{1'b1}} >> (8 * k));
        ocode = (d[63:56] == CH_SIG) ? OC_SIG : OC_SEQ;
        case (cls)
            CLS_D:   encode_block = {SYNC_DATA, d};
            CLS_C:   encode_block = {SYNC_CTRL, BT_CTRL, codes};
            CLS_S:   encode_block = {SYNC_CTRL, BT_START, d[55:0]};
            CLS_O:   encode_block = {SYNC_CTRL, BT_OSET, d[55:32], ocode, 28'h0};
            CLS_T:   encode_block = {SYNC_CTRL, term_type(k), d[63:8] & keep};
            default: encode_block = EBLOCK;
        endcase
    endfunction

    // Next-state and next coded block from the current state and input class
    always_comb begin
        state_next = TX_E;
        case (state_p1)
            TX_INIT, TX_C, TX_T: begin
                if (blk_class == CLS_C || blk_class == CLS_O) state_next = TX_C;
                else if (blk_class == CLS_S)                  state_next = TX_D;
                else                                          state_next = TX_E;
            end
            TX_D: begin
                if (blk_class == CLS_D)      state_next = TX_D;
                else if (blk_class == CLS_T) state_next = TX_T;
                else                         state_next = TX_E;
            end
            TX_E: begin
                if (blk_class == CLS_D || blk_class == CLS_S)      state_next = TX_D;
                else if (blk_class == CLS_T)                       state_next = TX_T;
                else if (blk_class == CLS_C || blk_class == CLS_O) state_next = TX_C;
                else                                               state_next = TX_E;
            end
            default: state_next = TX_E;
        endcase
        coded_next = (state_next == TX_E) ? EBLOCK
                                          : encode_block(blk_class, term_k, bus.i_tx_data);
    end

    // TX state register, advanced only on enabled clocks
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset)           state_p1 <= TX_INIT;
        else if (bus.i_enable) state_p1 <= state_next;
    end

    // ---- output stage p1: coded block and its valid flag ----
    // Coded block held while disabled; valid marks an enabled update
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            coded_p1 <= EBLOCK;
            vld_p1   <= 1'b0;
        end else if (bus.i_enable) begin
            coded_p1 <= coded_next;
            vld_p1   <= 1'b1;
        end else begin
            vld_p1   <= 1'b0;
        end
    end

    assign bus.o_tx_coded = coded_p1;
    assign bus.o_valid    = vld_p1;
    assign bus.o_state    = state_p1;

`ifdef ENCODER_ERROR_COUNT_EN
    logic [15:0] err_cnt_p1;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Count every error block emitted, sticking at all-ones
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset)                                    err_cnt_p1 <= 16'h0;
        else if (bus.i_enable && state_next == TX_E)    err_cnt_p1 <= sat_inc(err_cnt_p1);
    end

    assign bus.o_err_count = err_cnt_p1;
`endif

endmodule

// File: tb/tb_encoder_64b66b.sv
// Directed bench for encoder_64b66b with hand-computed coded blocks.
module tb_encoder_64b66b;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    localparam logic [65:0] EBLK   = {2'b10, 8'h1E, 56'h3C78F1E3C78F1E};
    localparam logic [4:0]  S_INIT = 5'b00001;
    localparam logic [4:0]  S_C    = 5'b00010;
    localparam logic [4:0]  S_D    = 5'b00100;
    localparam logic [4:0]  S_T    = 5'b01000;
    localparam logic [4:0]  S_E    = 5'b10000;

    encoder_64b66b_if bus ();

    encoder_64b66b dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [7:0] c, input logic [63:0] d);
        bus.i_tx_ctrl = c;
        bus.i_tx_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [65:0] blk,
                              input logic [4:0] st, input logic v);
        check({tag, "_blk"},   bus.o_tx_coded,    blk);
        check({tag, "_state"}, 66'(bus.o_state),  66'(st));
        check({tag, "_valid"}, 66'(bus.o_valid),  66'(v));
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        clk           = 1'b0;
        rst           = 1'b1;
        bus.i_enable  = 1'b1;
        bus.i_tx_ctrl = 8'h00;
        bus.i_tx_data = 64'h0;
        repeat (2) @(posedge clk);
        #1;
        expect_out("reset", EBLK, S_INIT, 1'b0);
`ifdef ENCODER_ERROR_COUNT_EN
        check("errcnt_reset", 66'(bus.o_err_count), 66'h0);
`endif
        rst = 1'b0;

        drive(8'hFF, 64'h0707070707070707);
        expect_out("idle", {2'b10, 8'h1E, 56'h0}, S_C, 1'b1);
        drive(8'h80, 64'h9C68797300000000);
        expect_out("oset_9c", {2'b10, 8'h4B, 56'h68797300000000}, S_C, 1'b1);
        drive(8'h80, 64'h5C01020300000000);
        expect_out("oset_5c", {2'b10, 8'h4B, 56'h010203F0000000}, S_C, 1'b1);
        drive(8'h80, 64'hFB11223344556677);
        expect_out("start", {2'b10, 8'h78, 56'h11223344556677}, S_D, 1'b1);
        drive(8'h00, 64'hAAAAAAAAAAAAAAAA);
        expect_out("data", {2'b01, 64'hAAAAAAAAAAAAAAAA}, S_D, 1'b1);
        drive(8'h1F, 64'h010203FD07070707);
        expect_out("term3", {2'b10, 8'hB4, 56'h01020300000000}, S_T, 1'b1);
        drive(8'h80, 64'hFB01020304050607);
        expect_out("t_then_s", {2'b10, 8'h78, 56'h01020304050607}, S_D, 1'b1);
        drive(8'hFF, 64'hFD07070707070707);
        expect_out("term0", {2'b10, 8'h87, 56'h0}, S_T, 1'b1);
        drive(8'h00, 64'h0123456789ABCDEF);
        expect_out("t_then_d", EBLK, S_E, 1'b1);
        drive(8'hFF, 64'h07FE070707070707);
        expect_out("ctrl_err_lane", {2'b10, 8'h1E, 56'h00780000000000}, S_C, 1'b1);
        drive(8'h00, 64'h5555555555555555);
        expect_out("c_then_d", EBLK, S_E, 1'b1);
        drive(8'h80, 64'hFBA1A2A3A4A5A6A7);
        expect_out("recover_s", {2'b10, 8'h78, 56'hA1A2A3A4A5A6A7}, S_D, 1'b1);
        drive(8'h01, 64'h11223344556677FD);
        expect_out("term7", {2'b10, 8'hFF, 56'h11223344556677}, S_T, 1'b1);
        drive(8'h80, 64'h0000000000000000);
        expect_out("bad_class", EBLK, S_E, 1'b1);
        drive(8'h00, 64'h0F0F0F0F0F0F0F0F);
        expect_out("e_then_d", {2'b01, 64'h0F0F0F0F0F0F0F0F}, S_D, 1'b1);
        drive(8'h07, 64'h1122334455FD0707);
        expect_out("term5", {2'b10, 8'hD2, 56'h11223344550000}, S_T, 1'b1);
        drive(8'hFF, 64'h0707070707070707);
        expect_out("idle2", {2'b10, 8'h1E, 56'h0}, S_C, 1'b1);
        drive(8'h80, 64'hFB00000000000001);
        expect_out("start2", {2'b10, 8'h78, 56'h00000000000001}, S_D, 1'b1);

        bus.i_enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(8'h1F, 64'h010203FD07070707);
            expect_out("hold", {2'b10, 8'h78, 56'h00000000000001}, S_D, 1'b0);
        end
        bus.i_enable = 1'b1;
        drive(8'h00, 64'hCAFEBABEDEADBEEF);
        expect_out("resume", {2'b01, 64'hCAFEBABEDEADBEEF}, S_D, 1'b1);

        rst = 1'b1;
        #2;
        expect_out("async_reset", EBLK, S_INIT, 1'b0);
        #1;
        rst = 1'b0;
        drive(8'h00, 64'h1111111111111111);
        expect_out("init_then_d", EBLK, S_E, 1'b1);
        drive(8'h7F, 64'h42FD070707070707);
        expect_out("term1", {2'b10, 8'h99, 56'h42000000000000}, S_T, 1'b1);

`ifdef ENCODER_ERROR_COUNT_EN
        bus.i_tx_ctrl = 8'h80;
        bus.i_tx_data = 64'h0;
        repeat (70000) @(posedge clk);
        #1;
        check("errcnt_sat", 66'(bus.o_err_count), 66'hFFFF);
        check("errcnt_state", 66'(bus.o_state), 66'(S_E));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
